spectrum_frame_buffer: RTL and testbench
========================================

Name: spectrum_frame_buffer

Overview:
- Parametrised successor to the spectrum renderer's input stage.
- Snapshots an N-bin FFT magnitude frame on i_fft_done and converts each bin to a log2 level, one bin per cycle.
- Applies optional fall-limited smoothing and a per-bin peak-hold with timed decay.
- Commits level and peak arrays to the display-side registers only while i_VGA_lock is low, so the spectrum renderer never sees a torn frame.

Parameters:
- N_BINS, 16, number of spectrum bins (2..64).
- IN_W, 16, magnitude width per bin.
- LVL_W, 4, level width; level saturates at 2^LVL_W-1.
- HOLD_FRAMES, 30, number of commits a new peak is held before it decays.
- HOLD_W, 6, hold counter width; HOLD_FRAMES must be < 2^HOLD_W.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_fft_data  in  N_BINS*IN_W  packed magnitudes; bin k occupies bits [k*IN_W +: IN_W].
- i_fft_done  in  1  one-cycle pulse; i_fft_data is valid in the same cycle.
- i_VGA_lock  in  1  high during active video; commit is allowed only when low.
- i_mode  in  1  0 = direct level, 1 = fall-limited level.
- o_level  out  N_BINS*LVL_W  committed levels, packed as for the input.
- o_peak  out  N_BINS*LVL_W  committed peak markers.
- o_frame_valid  out  1  one-cycle pulse in the cycle after a commit edge.
- o_busy  out  1  high in every state except S_IDLE.
- o_drop_cnt  out  8  saturating count of i_fft_done pulses ignored while busy.

Behaviour:
- Reset, synchronous: at the first edge with i_rst=1, o_level, o_peak, o_frame_valid, o_busy, o_drop_cnt, all hold counters, the snapshot and the shadow registers go to 0; state goes to S_IDLE. Reset mid-frame abandons the frame, and no commit follows.
- Level function: for x=0, L(x)=0. Otherwise L(x)=min(msb_index(x)+1, 2^LVL_W-1). With defaults: 1→1, 0x00FF→8, 0x8000→15 (saturated).
- States and transitions:
  - S_IDLE: when i_fft_done=1, latch i_fft_data into the snapshot, set idx=0 and go to S_PROC.
  - S_PROC: each cycle processes bin idx: n=L(snapshot[idx]), d=o_level[idx], p=o_peak[idx], h=hold[idx].
    - shadow_lvl[idx] = (i_mode==1 and d>0) ? max(n, d-1) : n.
    - If shadow_lvl>=p: shadow_pk=shadow_lvl and h=HOLD_FRAMES.
    - Else if h>0: shadow_pk=p and h=h-1.
    - Else: shadow_pk=max(p-1, shadow_lvl).
    - After bin N_BINS-1, go to S_WAIT_BLANK. The phase takes exactly N_BINS cycles.
  - S_WAIT_BLANK: at the first edge with i_VGA_lock=0, copy both shadow arrays to o_level/o_peak, assert o_frame_valid for the following cycle, and go to S_IDLE. While i_VGA_lock=1, wait indefinitely.
- i_mode is sampled per bin during S_PROC. A mid-frame change affects only the bins not yet processed.
- Outputs change only on commit edges; they are stable throughout active video.
- Minimum latency: i_fft_done sampled at edge E0 → commit at edge E0+N_BINS+1 → o_frame_valid high in the cycle after that edge.
- Drops: i_fft_done=1 in any state other than S_IDLE increments o_drop_cnt (saturates at 255). The in-flight frame is unaffected.
- Simultaneous events:
  - i_fft_done in the same cycle as the commit edge counts as a drop, because the state is not S_IDLE.
  - i_fft_done in S_IDLE in the cycle right after o_frame_valid is accepted.
- Hold counters change only during S_PROC. Since every processed frame is committed (absent reset), counter state always matches the committed peaks.

Test Plan:
- Reset, then a frame with all bins 0x00FF, mode 0, i_VGA_lock=0 → after 18 cycles all o_level=8 and all o_peak=8; o_frame_valid pulses once; o_drop_cnt=0.
- Bin 3 = 0x8000 and bin 5 = 0x0001, others 0 → o_level[3]=15, o_level[5]=1, other bins 0.
- Mode 1: frame with all bins 0x8000, then 4 frames with all bins 0 → levels read 15, 14, 13, 12, 11.
- Peak hold: one frame with bin 0 = 0x8000, then zero frames → o_peak[0]=15 for 31 commits, then 14, 13, ... down to 0.
- i_VGA_lock held high for 100 cycles after processing → no output change and o_busy=1; lock drops → commit on the next edge. A second i_fft_done during the wait → o_drop_cnt=1.
- i_rst pulsed during S_PROC at idx=7 → next cycle all outputs are 0, no o_frame_valid follows, and a new i_fft_done is accepted.

Source files
------------

// File: rtl/spectrum_frame_buffer_if.sv
// spectrum_frame_buffer_if
// Purpose: groups the FFT input bus, the video-lock and mode controls, and the
//          committed display outputs of spectrum_frame_buffer into one bundle.
// Signals:
//   i_fft_data    packed magnitudes, bin k at [k*IN_W +: IN_W]
//   i_fft_done    one-cycle pulse, i_fft_data valid in the same cycle
//   i_VGA_lock    high during active video, commit only while low
//   i_mode        0 = direct level, 1 = fall-limited level
//   o_level       committed levels, bin k at [k*LVL_W +: LVL_W]
//   o_peak        committed peak markers, packed as o_level
//   o_frame_valid one-cycle pulse in the cycle after a commit
//   o_busy        high whenever the buffer is not idle
//   o_drop_cnt    saturating count of ignored i_fft_done pulses
// Modports: master drives the inputs (FFT/video side), slave is the buffer.
interface spectrum_frame_buffer_if #(
   parameter int N_BINS = 16,
   parameter int IN_W   = 16,
   parameter int LVL_W  = 4
);
   logic [N_BINS*IN_W-1:0]  i_fft_data;
   logic                    i_fft_done;
   logic                    i_VGA_lock;
   logic                    i_mode;
   logic [N_BINS*LVL_W-1:0] o_level;
   logic [N_BINS*LVL_W-1:0] o_peak;
   logic                    o_frame_valid;
   logic                    o_busy;
   logic [7:0]              o_drop_cnt;

   modport master (
      output i_fft_data, i_fft_done, i_VGA_lock, i_mode,
      input  o_level, o_peak, o_frame_valid, o_busy, o_drop_cnt
   );

   modport slave (
      input  i_fft_data, i_fft_done, i_VGA_lock, i_mode,
      output o_level, o_peak, o_frame_valid, o_busy, o_drop_cnt
   );
endinterface

// File: rtl/spectrum_frame_buffer.sv
// spectrum_frame_buffer
// Purpose: snapshots an N_BINS FFT magnitude frame, converts each bin to a
//          saturating log2 level one bin per cycle, applies optional
//          fall-limited smoothing and a per-bin peak hold with timed decay,
//          and commits the result to the display registers only while the
//          video lock is low so the renderer never sees a torn frame.
// Ports:
//   i_clk  system clock
//   i_rst  synchronous active-high reset
//   bus    spectrum_frame_buffer_if.slave (FFT input, controls, outputs)
module spectrum_frame_buffer #(
   parameter int N_BINS      = 16,
   parameter int IN_W        = 16,
   parameter int LVL_W       = 4,
   parameter int HOLD_FRAMES = 30,
   parameter int HOLD_W      = 6
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   spectrum_frame_buffer_if.slave bus
);

   localparam int IDX_W   = (N_BINS > 1) ? $clog2(N_BINS) : 1;
   localparam int LVL_MAX = (1 << LVL_W) - 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PROC,
      S_WAIT_BLANK
   } state_t;

   state_t            r_state;
   logic [IDX_W-1:0]  r_idx;
   logic [IN_W-1:0]   r_snap      [N_BINS];
   logic [LVL_W-1:0]  r_shadowLvl [N_BINS];
   logic [LVL_W-1:0]  r_shadowPk  [N_BINS];
   logic [LVL_W-1:0]  r_level     [N_BINS];
   logic [LVL_W-1:0]  r_peak      [N_BINS];
   logic [HOLD_W-1:0] r_hold      [N_BINS];
   logic              r_frameValid;
   logic [7:0]        r_dropCnt;

   logic [LVL_W-1:0]  w_new;
   logic [LVL_W-1:0]  w_disp;
   logic [LVL_W-1:0]  w_dispDec;
   logic [LVL_W-1:0]  w_peakCur;
   logic [LVL_W-1:0]  w_peakDec;
   logic [HOLD_W-1:0] w_holdCur;
   logic [LVL_W-1:0]  w_lvl;
   logic [LVL_W-1:0]  w_pk;
   logic [HOLD_W-1:0] w_holdNext;

   // Bit length of x (index of the highest set bit plus one), clipped to the
   // largest representable level; zero maps to zero.
   function automatic logic [LVL_W-1:0] levelOf(input logic [IN_W-1:0] x);
      int pos;
      pos = 0;
      for (int b = 0; b < IN_W; b++) begin
         if (x[b]) pos = b + 1;
      end
      if (pos > LVL_MAX) pos = LVL_MAX;
      return LVL_W'(pos);
   endfunction

   // Per-bin update for the bin currently addressed by r_idx. The fall limit
   // lets a level drop by at most one step per frame; the peak either jumps
   // up to the new level (re-arming the hold timer), holds while the timer
   // runs, or decays one step per frame but never below the current level.
   always_comb begin
      w_new      = levelOf(r_snap[r_idx]);
      w_disp     = r_level[r_idx];
      w_dispDec  = w_disp - LVL_W'(1);
      w_peakCur  = r_peak[r_idx];
      w_peakDec  = w_peakCur - LVL_W'(1);
      w_holdCur  = r_hold[r_idx];
      w_lvl      = w_new;
      w_pk       = w_peakCur;
      w_holdNext = w_holdCur;
      if (bus.i_mode && (w_disp != '0) && (w_dispDec > w_new)) begin
         w_lvl = w_dispDec;
      end
      if (w_lvl >= w_peakCur) begin
         w_pk       = w_lvl;
         w_holdNext = HOLD_W'(HOLD_FRAMES);
      end else if (w_holdCur != '0) begin
         w_pk       = w_peakCur;
         w_holdNext = w_holdCur - HOLD_W'(1);
      end else begin
         w_pk = (w_peakDec > w_lvl) ? w_peakDec : w_lvl;
      end
   end

   // Main controller: snapshot on i_fft_done, walk the bins into the shadow
   // arrays, then wait for video blanking before committing both arrays at
   // once. Hold counters only move while processing, so they always track
   // the peaks that will be committed at the end of the same frame.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_frameValid <= 1'b0;
         r_dropCnt    <= '0;
         for (int k = 0; k < N_BINS; k++) begin
            r_snap[k]      <= '0;
            r_shadowLvl[k] <= '0;
            r_shadowPk[k]  <= '0;
            r_level[k]     <= '0;
            r_peak[k]      <= '0;
            r_hold[k]      <= '0;
         end
      end else begin
         r_frameValid <= 1'b0;
         if (bus.i_fft_done && (r_state != S_IDLE) && (r_dropCnt != 8'hFF)) begin
            r_dropCnt <= r_dropCnt + 8'd1;
         end
         case (r_state)
            S_IDLE: begin
               if (bus.i_fft_done) begin
                  for (int k = 0; k < N_BINS; k++) begin
                     r_snap[k] <= bus.i_fft_data[k*IN_W +: IN_W];
                  end
                  r_idx   <= '0;
                  r_state <= S_PROC;
               end
            end
            S_PROC: begin
               r_shadowLvl[r_idx] <= w_lvl;
               r_shadowPk[r_idx]  <= w_pk;
               r_hold[r_idx]      <= w_holdNext;
               if (r_idx == IDX_W'(N_BINS - 1)) begin
                  r_idx   <= '0;
                  r_state <= S_WAIT_BLANK;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            S_WAIT_BLANK: begin
               if (!bus.i_VGA_lock) begin
                  for (int k = 0; k < N_BINS; k++) begin
                     r_level[k] <= r_shadowLvl[k];
                     r_peak[k]  <= r_shadowPk[k];
                  end
                  r_frameValid <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Flatten the committed arrays onto the packed output buses.
   always_comb begin
      bus.o_level = '0;
      bus.o_peak  = '0;
      for (int k = 0; k < N_BINS; k++) begin
         bus.o_level[k*LVL_W +: LVL_W] = r_level[k];
         bus.o_peak[k*LVL_W +: LVL_W]  = r_peak[k];
      end
   end

   assign bus.o_frame_valid = r_frameValid;
   assign bus.o_busy        = (r_state != S_IDLE);
   assign bus.o_drop_cnt    = r_dropCnt;

endmodule

// File: tb/tb_spectrum_frame_buffer.sv
// tb_spectrum_frame_buffer
// Purpose: self-checking bench for spectrum_frame_buffer with default
//          parameters, comparing the committed outputs against a frame-level
//          reference model of the level, smoothing, peak-hold and drop rules.
module tb_spectrum_frame_buffer;

   localparam int N      = 16;
   localparam int IN_W   = 16;
   localparam int LVL_W  = 4;
   localparam int HOLD   = 30;
   localparam int LMAX   = 15;
   localparam int LAT    = N + 2;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   int   mLevel [N];
   int   mPeak  [N];
   int   mHold  [N];
   int   mDrop;

   spectrum_frame_buffer_if #(.N_BINS(N), .IN_W(IN_W), .LVL_W(LVL_W)) bus ();

   spectrum_frame_buffer #(
      .N_BINS(N), .IN_W(IN_W), .LVL_W(LVL_W), .HOLD_FRAMES(HOLD), .HOLD_W(6)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Level of a magnitude: number of bits needed to write it, clipped.
   function automatic int lvlOf(input int x);
      int v;
      int t;
      v = 0;
      t = x;
      while (t > 0) begin
         t = t / 2;
         v++;
      end
      return (v > LMAX) ? LMAX : v;
   endfunction

   // Advance the reference model by one committed frame.
   function automatic void modelFrame(input logic [N*IN_W-1:0] data, input bit mode);
      int n, d, p, h, s, pk;
      for (int k = 0; k < N; k++) begin
         n = lvlOf(int'(data[k*IN_W +: IN_W]));
         d = mLevel[k];
         p = mPeak[k];
         h = mHold[k];
         s = (mode && d > 0) ? ((n > d - 1) ? n : d - 1) : n;
         if (s >= p) begin
            pk = s;
            h  = HOLD;
         end else if (h > 0) begin
            pk = p;
            h  = h - 1;
         end else begin
            pk = (p - 1 > s) ? p - 1 : s;
         end
         mLevel[k] = s;
         mPeak[k]  = pk;
         mHold[k]  = h;
      end
   endfunction

   function automatic logic [N*LVL_W-1:0] packArr(input int a [N]);
      logic [N*LVL_W-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++) r[k*LVL_W +: LVL_W] = LVL_W'(a[k]);
      return r;
   endfunction

   function automatic void modelReset();
      for (int k = 0; k < N; k++) begin
         mLevel[k] = 0;
         mPeak[k]  = 0;
         mHold[k]  = 0;
      end
      mDrop = 0;
   endfunction

   // Reset pulse for two cycles; called and returns at a falling edge.
   task automatic doReset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      modelReset();
   endtask

   // Send one frame starting at the current falling edge and wait for its
   // o_frame_valid pulse. dropAt > 0 pulses i_fft_done again at that
   // falling edge count. Returns the cycle count or -1 on timeout.
   task automatic applyStimulus(input logic [N*IN_W-1:0] data, input bit mode,
                                input int dropAt, output int latency);
      int c;
      modelFrame(data, mode);
      bus.i_fft_data = data;
      bus.i_mode     = mode;
      bus.i_fft_done = 1'b1;
      c       = 0;
      latency = -1;
      while (c < 200 && latency < 0) begin
         @(negedge clk);
         c++;
         bus.i_fft_done = 1'b0;
         if (c == dropAt) begin
            bus.i_fft_done = 1'b1;
            if (mDrop < 255) mDrop++;
         end
         if (bus.o_frame_valid === 1'b1) latency = c;
      end
      bus.i_fft_done = 1'b0;
      if (latency < 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL frame_timeout: no o_frame_valid within %0d cycles", c);
      end
   endtask

   function automatic logic [N*IN_W-1:0] fillAll(input logic [IN_W-1:0] v);
      logic [N*IN_W-1:0] r;
      for (int k = 0; k < N; k++) r[k*IN_W +: IN_W] = v;
      return r;
   endfunction

   task automatic test_reset();
      doReset();
      checks++;
      if (bus.o_level !== '0 || bus.o_peak !== '0 || bus.o_frame_valid !== 1'b0 ||
          bus.o_busy !== 1'b0 || bus.o_drop_cnt !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_state: level=%h peak=%h fv=%b busy=%b drop=%0d required all zero",
                  bus.o_level, bus.o_peak, bus.o_frame_valid, bus.o_busy, bus.o_drop_cnt);
      end
   endtask

   task automatic test_all_ff();
      int lat;
      int pulses;
      logic [N*LVL_W-1:0] exp8;
      exp8 = '0;
      for (int k = 0; k < N; k++) exp8[k*LVL_W +: LVL_W] = 4'd8;
      applyStimulus(fillAll(16'h00FF), 1'b0, 0, lat);
      checks++;
      if (lat !== LAT) begin
         errors++;
         $display("[TB] FAIL latency: got %0d cycles required %0d", lat, LAT);
      end
      checks++;
      if (bus.o_level !== exp8 || bus.o_peak !== exp8) begin
         errors++;
         $display("[TB] FAIL all_ff: level=%h peak=%h required %h", bus.o_level, bus.o_peak, exp8);
      end
      pulses = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.o_frame_valid === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0 || bus.o_drop_cnt !== 8'd0) begin
         errors++;
         $display("[TB] FAIL single_pulse: extra pulses=%0d drop=%0d required 0 and 0",
                  pulses, bus.o_drop_cnt);
      end
   endtask

   task automatic test_sparse();
      int lat;
      logic [N*IN_W-1:0]  d;
      logic [N*LVL_W-1:0] e;
      d = '0;
      d[3*IN_W +: IN_W] = 16'h8000;
      d[5*IN_W +: IN_W] = 16'h0001;
      e = '0;
      e[3*LVL_W +: LVL_W] = 4'd15;
      e[5*LVL_W +: LVL_W] = 4'd1;
      applyStimulus(d, 1'b0, 0, lat);
      checks++;
      if (bus.o_level !== e) begin
         errors++;
         $display("[TB] FAIL sparse_level: got %h required %h", bus.o_level, e);
      end
      checks++;
      if (bus.o_peak !== packArr(mPeak)) begin
         errors++;
         $display("[TB] FAIL sparse_peak: got %h required %h", bus.o_peak, packArr(mPeak));
      end
   endtask

   task automatic test_mode1_fall();
      int lat;
      bit ok;
      for (int f = 0; f < 5; f++) begin
         applyStimulus(fillAll((f == 0) ? 16'h8000 : 16'h0000), 1'b1, 0, lat);
         ok = 1'b1;
         for (int k = 0; k < N; k++) begin
            if (bus.o_level[k*LVL_W +: LVL_W] !== LVL_W'(15 - f)) ok = 1'b0;
         end
         checks++;
         if (!ok || bus.o_level !== packArr(mLevel)) begin
            errors++;
            $display("[TB] FAIL mode1_fall frame %0d: got %h required every bin %0d",
                     f, bus.o_level, 15 - f);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [N*IN_W-1:0] d;
      d = fillAll(16'h0F00);
      // i_fft_done in the cycle before the commit edge lands while waiting for
      // blanking and must count as a drop.
      applyStimulus(d, 1'b0, LAT - 1, lat);
      checks++;
      if (bus.o_drop_cnt !== 8'(mDrop) || bus.o_level !== packArr(mLevel)) begin
         errors++;
         $display("[TB] FAIL commit_edge_drop: drop=%0d level=%h required drop=%0d level=%h",
                  bus.o_drop_cnt, bus.o_level, mDrop, packArr(mLevel));
      end
      // Next frame starts in the o_frame_valid cycle itself and must be taken.
      applyStimulus(fillAll(16'h0003), 1'b0, 0, lat);
      checks++;
      if (lat !== LAT || bus.o_level !== packArr(mLevel) || bus.o_drop_cnt !== 8'(mDrop)) begin
         errors++;
         $display("[TB] FAIL back_to_back: lat=%0d level=%h drop=%0d required lat=%0d level=%h drop=%0d",
                  lat, bus.o_level, bus.o_drop_cnt, LAT, packArr(mLevel), mDrop);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      int pulses;
      bus.i_fft_data = fillAll(16'hFFFF);
      bus.i_mode     = 1'b0;
      bus.i_fft_done = 1'b1;
      @(negedge clk);
      bus.i_fft_done = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      modelReset();
      checks++;
      if (bus.o_level !== '0 || bus.o_peak !== '0 || bus.o_busy !== 1'b0 ||
          bus.o_frame_valid !== 1'b0 || bus.o_drop_cnt !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_mid: level=%h peak=%h busy=%b fv=%b drop=%0d required all zero",
                  bus.o_level, bus.o_peak, bus.o_busy, bus.o_frame_valid, bus.o_drop_cnt);
      end
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.o_frame_valid === 1'b1 || bus.o_busy === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("[TB] FAIL reset_abandon: %0d cycles showed busy or frame_valid, required 0", pulses);
      end
      applyStimulus(fillAll(16'h0010), 1'b0, 0, lat);
      checks++;
      if (lat !== LAT || bus.o_level !== packArr(mLevel) || bus.o_peak !== packArr(mPeak)) begin
         errors++;
         $display("[TB] FAIL reset_restart: lat=%0d level=%h required lat=%0d level=%h",
                  lat, bus.o_level, LAT, packArr(mLevel));
      end
   endtask

   task automatic test_vga_lock();
      logic [N*LVL_W-1:0] lvlBefore;
      logic [N*LVL_W-1:0] pkBefore;
      logic [N*IN_W-1:0]  d;
      int bad;
      for (int k = 0; k < N; k++) d[k*IN_W +: IN_W] = IN_W'($urandom);
      lvlBefore = bus.o_level;
      pkBefore  = bus.o_peak;
      modelFrame(d, 1'b0);
      bus.i_VGA_lock = 1'b1;
      bus.i_fft_data = d;
      bus.i_mode     = 1'b0;
      bus.i_fft_done = 1'b1;
      @(negedge clk);
      bus.i_fft_done = 1'b0;
      repeat (N + 1) @(negedge clk);
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         bus.i_fft_done = (c == 50);
         if (c == 50) mDrop++;
         if (bus.o_busy !== 1'b1 || bus.o_level !== lvlBefore ||
             bus.o_peak !== pkBefore || bus.o_frame_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL vga_hold: %0d of 100 locked cycles changed outputs or dropped busy, required 0", bad);
      end
      bus.i_fft_done = 1'b0;
      bus.i_VGA_lock = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.o_frame_valid !== 1'b1 || bus.o_level !== packArr(mLevel) ||
          bus.o_peak !== packArr(mPeak)) begin
         errors++;
         $display("[TB] FAIL vga_release: fv=%b level=%h peak=%h required fv=1 level=%h peak=%h",
                  bus.o_frame_valid, bus.o_level, bus.o_peak, packArr(mLevel), packArr(mPeak));
      end
      checks++;
      if (bus.o_drop_cnt !== 8'd1 || mDrop != 1) begin
         errors++;
         $display("[TB] FAIL vga_drop: drop=%0d required 1", bus.o_drop_cnt);
      end
   endtask

   task automatic test_peak_hold();
      int lat;
      int expPk;
      logic [N*IN_W-1:0] d;
      doReset();
      d = '0;
      d[IN_W-1:0] = 16'h8000;
      for (int i = 1; i <= 47; i++) begin
         applyStimulus((i == 1) ? d : '0, 1'b0, 0, lat);
         expPk = (i <= 31) ? 15 : ((15 - (i - 31) > 0) ? 15 - (i - 31) : 0);
         checks++;
         if (bus.o_peak[LVL_W-1:0] !== LVL_W'(expPk) || bus.o_peak !== packArr(mPeak)) begin
            errors++;
            $display("[TB] FAIL peak_hold commit %0d: peak0=%0d required %0d", i,
                     bus.o_peak[LVL_W-1:0], expPk);
         end
      end
   endtask

   task automatic test_random();
      int lat;
      bit mode;
      logic [N*IN_W-1:0] d;
      for (int f = 0; f < 25; f++) begin
         for (int k = 0; k < N; k++) begin
            d[k*IN_W +: IN_W] = IN_W'($urandom >> $urandom_range(16, 31));
         end
         mode = 1'($urandom_range(0, 1));
         applyStimulus(d, mode, 0, lat);
         checks++;
         if (lat !== LAT || bus.o_level !== packArr(mLevel) ||
             bus.o_peak !== packArr(mPeak) || bus.o_drop_cnt !== 8'(mDrop)) begin
            errors++;
            $display("[TB] FAIL random frame %0d mode %0d: lat=%0d level=%h peak=%h required lat=%0d level=%h peak=%h",
                     f, mode, lat, bus.o_level, bus.o_peak, LAT, packArr(mLevel), packArr(mPeak));
         end
      end
   endtask

   task automatic test_drop_saturate();
      int c;
      bit seen;
      logic [N*IN_W-1:0] d;
      d = fillAll(16'h0100);
      modelFrame(d, 1'b0);
      bus.i_VGA_lock = 1'b1;
      bus.i_fft_data = d;
      bus.i_mode     = 1'b0;
      bus.i_fft_done = 1'b1;
      @(negedge clk);
      bus.i_fft_done = 1'b0;
      for (int i = 0; i < 300; i++) begin
         bus.i_fft_done = 1'b1;
         if (mDrop < 255) mDrop++;
         @(negedge clk);
         bus.i_fft_done = 1'b0;
         @(negedge clk);
      end
      bus.i_VGA_lock = 1'b0;
      seen = 1'b0;
      c = 0;
      while (!seen && c < 50) begin
         @(negedge clk);
         c++;
         if (bus.o_frame_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || bus.o_drop_cnt !== 8'd255 || mDrop != 255 || bus.o_level !== packArr(mLevel)) begin
         errors++;
         $display("[TB] FAIL drop_saturate: seen=%b drop=%0d level=%h required seen=1 drop=255 level=%h",
                  seen, bus.o_drop_cnt, bus.o_level, packArr(mLevel));
      end
   endtask

   // Scenario sequence; all stimulus is driven at falling edges.
   initial begin
      checks         = 0;
      errors         = 0;
      rst            = 1'b0;
      bus.i_fft_data = '0;
      bus.i_fft_done = 1'b0;
      bus.i_VGA_lock = 1'b0;
      bus.i_mode     = 1'b0;
      modelReset();
      @(negedge clk);
      test_reset();
      test_all_ff();
      test_sparse();
      test_mode1_fall();
      test_back_to_back();
      test_reset_mid();
      test_vga_lock();
      test_peak_hold();
      test_random();
      test_drop_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
